// File: rtl/fp_16_to_32_convert_stream.sv
// Multi-lane elastic converter from binary16/bfloat16 to binary32 with NaN/subnormal flags.
// Define FP16_CVT_FTZ_EN to flush subnormal inputs to signed zero instead of normalising them.
module fp_16_to_32_convert_stream #(
  parameter int LANES       = 4,
  parameter int PIPE_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  fmt_i,
  input  logic [16*LANES-1:0]   operands_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [32*LANES-1:0]   results_o,
  output logic                  nan_o,
  output logic                  sub_o,
  input  logic                  clr_i,
  output logic                  nan_sticky_o,
  output logic                  sub_sticky_o
);

  localparam int DW   = 32 * LANES;
  localparam int LAST = PIPE_STAGES - 1;

  function automatic logic [31:0] cvt_lane(input logic [15:0] op, input logic fmt);
    logic       s;
    logic [4:0] e;
    logic [9:0] m;
    logic [31:0] r;
    s = op[15];
    e = op[14:10];
    m = op[9:0];
    if (fmt) begin
      r = {op, 16'h0};
`ifdef FP16_CVT_FTZ_EN
      if (op[14:7] == 8'h00) r = {s, 31'h0};
`endif
    end else if (e == 5'd0) begin
`ifdef FP16_CVT_FTZ_EN
      r = {s, 31'h0};
`else
      begin
        logic [3:0] p;
        p = 4'd0;
        for (int i = 0; i < 10; i++) begin
          if (m[i]) p = 4'(i);
        end
        // The shift pushes the leading one out of the 23-bit field, leaving the bits below it.
        if (m == 10'd0) r = {s, 31'h0};
        else            r = {s, 8'(p) + 8'd103, 23'({m, 13'h0} << (4'd10 - p))};
      end
`endif
    end else if (e == 5'h1F) begin
      r = {s, 8'hFF, m, 13'h0};
    end else begin
      r = {s, {3'b000, e} + 8'd112, m, 13'h0};
    end
    return r;
  endfunction

  function automatic logic lane_nan(input logic [15:0] op, input logic fmt);
    if (fmt) return (op[14:7] == 8'hFF) && (op[6:0] != 7'd0);
    else     return (op[14:10] == 5'h1F) && (op[9:0] != 10'd0);
  endfunction

  function automatic logic lane_sub(input logic [15:0] op, input logic fmt);
    if (fmt) return (op[14:7] == 8'h00) && (op[6:0] != 7'd0);
    else     return (op[14:10] == 5'h00) && (op[9:0] != 10'd0);
  endfunction

  logic [DW-1:0]          res_in;
  logic [LANES-1:0]       nan_in, sub_in;

  logic [PIPE_STAGES-1:0] vld_q, vld_d, load, src_vld;
  logic [DW-1:0]          res_q   [PIPE_STAGES];
  logic [DW-1:0]          res_d   [PIPE_STAGES];
  logic [DW-1:0]          src_res [PIPE_STAGES];
  logic [LANES-1:0]       nanl_q  [PIPE_STAGES];
  logic [LANES-1:0]       nanl_d  [PIPE_STAGES];
  logic [LANES-1:0]       src_nan [PIPE_STAGES];
  logic [LANES-1:0]       subl_q  [PIPE_STAGES];
  logic [LANES-1:0]       subl_d  [PIPE_STAGES];
  logic [LANES-1:0]       src_sub [PIPE_STAGES];
  logic                   chain;
  logic                   nan_sticky_q, nan_sticky_d;
  logic                   sub_sticky_q, sub_sticky_d;

  // Decode / normalise, ahead of stage 0
  always_comb begin
    res_in = '0;
    nan_in = '0;
    sub_in = '0;
    for (int k = 0; k < LANES; k++) begin
      res_in[32*k +: 32] = cvt_lane(operands_i[16*k +: 16], fmt_i);
      nan_in[k]          = lane_nan(operands_i[16*k +: 16], fmt_i);
      sub_in[k]          = lane_sub(operands_i[16*k +: 16], fmt_i);
    end
  end

  // A stage loads when empty or when the stage after it drains this cycle.
  always_comb begin
    chain = ready_i;
    load  = '0;
    for (int n = PIPE_STAGES - 1; n >= 0; n--) begin
      chain   = ~vld_q[n] | chain;
      load[n] = chain;
    end
  end

  always_comb begin
    src_vld    = '0;
    src_vld[0] = valid_i;
    src_res[0] = res_in;
    src_nan[0] = nan_in;
    src_sub[0] = sub_in;
    for (int n = 1; n < PIPE_STAGES; n++) begin
      src_vld[n] = vld_q[n-1];
      src_res[n] = res_q[n-1];
      src_nan[n] = nanl_q[n-1];
      src_sub[n] = subl_q[n-1];
    end
  end

  always_comb begin
    for (int n = 0; n < PIPE_STAGES; n++) begin
      vld_d[n]  = load[n] ? src_vld[n] : vld_q[n];
      res_d[n]  = (load[n] && src_vld[n]) ? src_res[n] : res_q[n];
      nanl_d[n] = (load[n] && src_vld[n]) ? src_nan[n] : nanl_q[n];
      subl_d[n] = (load[n] && src_vld[n]) ? src_sub[n] : subl_q[n];
    end
  end

  always_comb begin
    nan_sticky_d = (valid_o && ready_i && nan_o) || (nan_sticky_q && !clr_i);
    sub_sticky_d = (valid_o && ready_i && sub_o) || (sub_sticky_q && !clr_i);
  end

  // Pipeline stage registers: control is reset, data only follows its valid bit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q        <= '0;
      nan_sticky_q <= 1'b0;
      sub_sticky_q <= 1'b0;
    end else begin
      vld_q        <= vld_d;
      nan_sticky_q <= nan_sticky_d;
      sub_sticky_q <= sub_sticky_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int n = 0; n < PIPE_STAGES; n++) begin
      res_q[n]  <= res_d[n];
      nanl_q[n] <= nanl_d[n];
      subl_q[n] <= subl_d[n];
    end
  end

  // Output stage: gating by valid keeps results at zero after reset without resetting data
  always_comb begin
    ready_o      = load[0];
    valid_o      = vld_q[LAST];
    results_o    = valid_o ? res_q[LAST] : '0;
    nan_o        = valid_o && (|nanl_q[LAST]);
    sub_o        = valid_o && (|subl_q[LAST]);
    nan_sticky_o = nan_sticky_q;
    sub_sticky_o = sub_sticky_q;
  end

endmodule
